// File: rtl/vdp_pkg.sv
// Shared video-pipeline definitions: frame geometry, pixel word and fill-engine states.
package vdp_pkg;

    localparam int H_RES   = 256;
    localparam int V_RES   = 256;
    localparam int ADDR_W  = 16;
    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/vram_fill_if.sv
// Fill-command handshake plus the VRAM write port; slave is the engine, master the command source / RAM side.
interface vram_fill_if;
    import vdp_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [8:0]        cmd_w;
    logic [8:0]        cmd_h;
    pixel_t            cmd_color;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] vram_wadr;
    logic              vram_we;
    pixel_t            vram_d;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, vram_wadr, vram_we, vram_d
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, vram_wadr, vram_we, vram_d
    );

endinterface

// File: rtl/vram_fill.sv
// Rectangle-fill engine: clips one command to the frame and writes its colour one pixel per clock in raster order.
// First write the cycle after acceptance, done the cycle after the last write; commands are only taken while idle.
module vram_fill
    import vdp_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    vram_fill_if.slave bus
);

    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [8:0] V_LIM = 9'(V_RES);

    fill_state_t state_q, state_d;
    logic [8:0]  cx_q, cx_d;
    logic [8:0]  cy_q, cy_d;
    logic [8:0]  x0_q, x0_d;
    logic [8:0]  x_end_q, x_end_d;
    logic [8:0]  y_end_q, y_end_d;
    pixel_t      color_q, color_d;

    logic [8:0]  x_sum, y_sum, x_clip, y_clip;
    logic [8:0]  cx_inc, cy_inc;
    logic        accept, empty, last_col, last_row;

    // Cursor is 9 bits wide so column 255+1 reaches 256 and compares against x_end
    // instead of wrapping back to column 0 of the same line.
    always_comb begin
        x_sum    = {1'b0, bus.cmd_x} + bus.cmd_w;
        y_sum    = {1'b0, bus.cmd_y} + bus.cmd_h;
        x_clip   = (x_sum > H_LIM) ? H_LIM : x_sum;
        y_clip   = (y_sum > V_LIM) ? V_LIM : y_sum;
        cx_inc   = cx_q + 9'd1;
        cy_inc   = cy_q + 9'd1;
        last_col = (cx_inc == x_end_q);
        last_row = (cy_inc == y_end_q);
        accept   = (state_q == IDLE) && bus.cmd_valid;
        empty    = (bus.cmd_w == 9'd0) || (bus.cmd_h == 9'd0);
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x0_d    = x0_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        color_d = color_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    x0_d    = {1'b0, bus.cmd_x};
                    cx_d    = {1'b0, bus.cmd_x};
                    cy_d    = {1'b0, bus.cmd_y};
                    x_end_d = x_clip;
                    y_end_d = y_clip;
                    color_d = bus.cmd_color;
                    state_d = empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (last_col) begin
                    cx_d = x0_q;
                    cy_d = cy_inc;
                    if (last_row) begin
                        state_d = DONE;
                    end
                end else begin
                    cx_d = cx_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            color_q <= color_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == FILL);
    assign bus.done      = (state_q == DONE);
    assign bus.vram_we   = (state_q == FILL);
    assign bus.vram_wadr = {cy_q[7:0], cx_q[7:0]};
    assign bus.vram_d    = color_q;

endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill: fixed vector table, hand-written corner sequences and random fills.
module tb_vram_fill;
    import vdp_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    always #5 CLOCK_50 = ~CLOCK_50;

    vram_fill_if bus();

    vram_fill dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int     x;
        int     y;
        int     w;
        int     h;
        pixel_t c;
        int     exp_n;
        int     exp_last;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input bit ok, input string name, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, got, want);
        end
    endtask

    // Reference: every pixel inside the rectangle clipped to the frame, raster order.
    function automatic void model(input int x, input int y, input int w, input int h, ref int q[$]);
        int xe, ye;
        xe = (x + w > H_RES) ? H_RES : x + w;
        ye = (y + h > V_RES) ? V_RES : y + h;
        q.delete();
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
                q.push_back(yy * H_RES + xx);
    endfunction

    // Starts and ends on a falling edge; returns in the cycle right after acceptance.
    task automatic send(input int x, input int y, input int w, input int h, input pixel_t c, input bit hold);
        int t;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 200) begin
            @(negedge CLOCK_50);
            t++;
        end
        check(bus.cmd_ready === 1'b1, "ready_before_send", $sformatf("cmd_ready=%b", bus.cmd_ready), "cmd_ready=1");
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 9'(h);
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    // Called in the first cycle after acceptance; returns in the idle cycle after done.
    task automatic check_fill(input int x, input int y, input int w, input int h, input pixel_t c,
                              input string name, output int obs_n, output int obs_last);
        int exp_q[$];
        int obs_q[$];
        int bad_t, bad_d, cyc, diff;
        bad_t = 0;
        bad_d = 0;
        cyc   = 0;
        diff  = -1;
        model(x, y, w, h, exp_q);
        while (bus.done !== 1'b1 && cyc < exp_q.size() + 4) begin
            if (bus.vram_we === 1'b1 && bus.busy === 1'b1 && bus.cmd_ready === 1'b0)
                obs_q.push_back(int'(bus.vram_wadr));
            else
                bad_t++;
            if (bus.vram_we === 1'b1 && bus.vram_d !== c) bad_d++;
            cyc++;
            @(negedge CLOCK_50);
        end
        check(bus.done === 1'b1 && bus.vram_we === 1'b0 && bus.busy === 1'b0 && cyc == exp_q.size(),
              {name, "_done"},
              $sformatf("done=%b we=%b busy=%b after %0d cycles", bus.done, bus.vram_we, bus.busy, cyc),
              $sformatf("done=1 we=0 busy=0 after %0d cycles", exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (diff < 0 && obs_q[i] != exp_q[i]) diff = i;
        check(diff < 0 && obs_q.size() == exp_q.size(), {name, "_addr"},
              $sformatf("%0d writes, first diff idx %0d (adr %0d)", obs_q.size(), diff,
                        (diff >= 0) ? obs_q[diff] : -1),
              $sformatf("%0d writes in raster order (adr %0d)", exp_q.size(), (diff >= 0) ? exp_q[diff] : -1));
        check(bad_t == 0, {name, "_nobubble"}, $sformatf("%0d bad cycles", bad_t), "0 bad cycles");
        check(bad_d == 0, {name, "_data"}, $sformatf("%0d wrong colour writes", bad_d), $sformatf("all %h", c));
        @(negedge CLOCK_50);
        check(bus.cmd_ready === 1'b1 && bus.done === 1'b0 && bus.vram_we === 1'b0, {name, "_ready"},
              $sformatf("ready=%b done=%b we=%b", bus.cmd_ready, bus.done, bus.vram_we), "ready=1 done=0 we=0");
        obs_n    = obs_q.size();
        obs_last = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : -1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, bad;
        pixel_t c;

        tbl[0] = '{x: 10,  y: 20,  w: 3,   h: 2,   c: 24'hFF0000, exp_n: 6,     exp_last: 5388};
        tbl[1] = '{x: 250, y: 254, w: 20,  h: 10,  c: 24'h00FF00, exp_n: 12,    exp_last: 65535};
        tbl[2] = '{x: 7,   y: 7,   w: 0,   h: 5,   c: 24'h123456, exp_n: 0,     exp_last: -1};
        tbl[3] = '{x: 3,   y: 3,   w: 5,   h: 0,   c: 24'h654321, exp_n: 0,     exp_last: -1};
        tbl[4] = '{x: 255, y: 255, w: 1,   h: 1,   c: 24'hABCDEF, exp_n: 1,     exp_last: 65535};
        tbl[5] = '{x: 0,   y: 5,   w: 256, h: 1,   c: 24'h0F0F0F, exp_n: 256,   exp_last: 1535};
        tbl[6] = '{x: 0,   y: 0,   w: 256, h: 256, c: 24'h0000FF, exp_n: 65536, exp_last: 65535};

        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;

        repeat (3) @(negedge CLOCK_50);
        check(bus.cmd_ready === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0 && bus.vram_we === 1'b0 &&
              bus.vram_wadr === '0 && bus.vram_d === '0, "reset_state",
              $sformatf("ready=%b busy=%b done=%b we=%b adr=%0d d=%h", bus.cmd_ready, bus.busy, bus.done,
                        bus.vram_we, bus.vram_wadr, bus.vram_d),
              "ready=1 busy=0 done=0 we=0 adr=0 d=0");
        reset = 1'b0;
        @(negedge CLOCK_50);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c, 1'b0);
            check_fill(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c, $sformatf("vec%0d", i), n, last);
            check(n == tbl[i].exp_n, $sformatf("vec%0d_count", i), $sformatf("%0d", n), $sformatf("%0d", tbl[i].exp_n));
            check(last == tbl[i].exp_last, $sformatf("vec%0d_last", i), $sformatf("%0d", last),
                  $sformatf("%0d", tbl[i].exp_last));
        end

        // Second command held valid through the first fill must be taken exactly once.
        send(100, 100, 4, 3, 24'h111111, 1'b1);
        bus.cmd_x     = 8'd5;
        bus.cmd_y     = 8'd6;
        bus.cmd_w     = 9'd2;
        bus.cmd_h     = 9'd2;
        bus.cmd_color = 24'h222222;
        check_fill(100, 100, 4, 3, 24'h111111, "b2b_first", n, last);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.cmd_valid = 1'b0;
        check_fill(5, 6, 2, 2, 24'h222222, "b2b_second", n, last);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.vram_we !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
            @(negedge CLOCK_50);
        end
        check(bad == 0, "b2b_no_extra", $sformatf("%0d active cycles", bad), "0 active cycles");

        // Reset landing on the 4th write of a 4x4 fill.
        send(0, 0, 4, 4, 24'h333333, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.vram_we !== 1'b1 || int'(bus.vram_wadr) != i) bad++;
            if (i < 3) @(negedge CLOCK_50);
        end
        check(bad == 0, "rst_pre_writes", $sformatf("%0d bad writes", bad), "writes 0..3");
        reset = 1'b1;
        @(negedge CLOCK_50);
        check(bus.vram_we === 1'b0 && bus.done === 1'b0, "rst_mid_we",
              $sformatf("we=%b done=%b", bus.vram_we, bus.done), "we=0 done=0");
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check(bus.cmd_ready === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0 && bus.vram_we === 1'b0,
              "rst_release", $sformatf("ready=%b busy=%b done=%b we=%b", bus.cmd_ready, bus.busy, bus.done,
                                       bus.vram_we), "ready=1 busy=0 done=0 we=0");

        for (int k = 0; k < 20; k++) begin
            int rx, ry, rw, rh, gap;
            rx  = $urandom_range(0, 255);
            ry  = $urandom_range(0, 255);
            rw  = $urandom_range(0, 24);
            rh  = $urandom_range(0, 24);
            c   = pixel_t'($urandom);
            gap = $urandom_range(0, 2);
            send(rx, ry, rw, rh, c, 1'b0);
            check_fill(rx, ry, rw, rh, c, $sformatf("rnd%0d", k), n, last);
            repeat (gap) @(negedge CLOCK_50);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
